// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: aligns store lanes, runs a req/ready handshake
// to a variable-latency data memory and registers the retired word for write-back.
module mem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ReqValidM,
   input  logic              MemReadM,
   input  logic [1:0]        StoreSizeM,
   input  logic [2:0]        RegWriteM,
   input  logic [ADDR_W-1:0] AluOutM,
   input  logic [31:0]       StoreDataM,
   output logic              StallM,
   output logic              MisalignM,
   output logic              MemReq,
   output logic [ADDR_W-3:0] MemAddr,
   output logic [3:0]        MemWE,
   output logic [31:0]       MemWD,
   input  logic              MemRdy,
   input  logic [31:0]       MemRD,
   output logic              ValidW,
   output logic [31:0]       WordW,
   output logic [1:0]        ByteSelW,
   output logic [2:0]        RegWriteW
);

   localparam logic [2:0] NOREGWRITE = 3'd0;
   localparam logic [2:0] LB         = 3'd1;
   localparam logic [2:0] LH         = 3'd2;
   localparam logic [2:0] LW         = 3'd3;
   localparam logic [2:0] LBU        = 3'd4;
   localparam logic [2:0] LHU        = 3'd5;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t            state_r, state_nx_s;
   logic              is_store_s, mem_op_s, misalign_s;
   logic [1:0]        lane_s;
   logic [3:0]        we_align_s;
   logic [31:0]       wd_align_s;

   logic              pend_load_r, pend_load_nx_s;
   logic [1:0]        pend_bsel_r, pend_bsel_nx_s;
   logic [2:0]        pend_mode_r, pend_mode_nx_s;

   logic              mem_req_nx_s;
   logic [ADDR_W-3:0] mem_addr_nx_s;
   logic [3:0]        mem_we_nx_s;
   logic [31:0]       mem_wd_nx_s;
   logic              valid_nx_s;
   logic [31:0]       word_nx_s;
   logic [1:0]        bsel_nx_s;
   logic [2:0]        mode_nx_s;

   // Decode the M-stage op: lane enables, aligned write data and misalignment.
   always_comb begin
      lane_s     = AluOutM[1:0];
      is_store_s = (StoreSizeM != 2'b00);
      mem_op_s   = ReqValidM & (MemReadM | is_store_s);
      wd_align_s = StoreDataM << {lane_s, 3'b000};
      case (StoreSizeM)
         2'b01:   we_align_s = 4'b0001 << lane_s;
         2'b10:   we_align_s = 4'b0011 << lane_s;
         2'b11:   we_align_s = 4'b1111;
         default: we_align_s = 4'b0000;
      endcase
      // A store wins over MemReadM, so its size decides alignment, not the load mode.
      if (is_store_s) begin
         case (StoreSizeM)
            2'b10:   misalign_s = lane_s[0];
            2'b11:   misalign_s = (lane_s != 2'b00);
            default: misalign_s = 1'b0;
         endcase
      end else begin
         case (RegWriteM)
            LH, LHU: misalign_s = lane_s[0];
            LW:      misalign_s = (lane_s != 2'b00);
            LB, LBU: misalign_s = 1'b0;
            default: misalign_s = 1'b0;
         endcase
      end
   end

   // Next-state, stall/misalign outputs and next values of all registered outputs.
   always_comb begin
      state_nx_s     = state_r;
      StallM         = 1'b0;
      MisalignM      = 1'b0;
      mem_req_nx_s   = MemReq;
      mem_addr_nx_s  = MemAddr;
      mem_we_nx_s    = MemWE;
      mem_wd_nx_s    = MemWD;
      valid_nx_s     = 1'b0;
      word_nx_s      = WordW;
      bsel_nx_s      = ByteSelW;
      mode_nx_s      = RegWriteW;
      pend_load_nx_s = pend_load_r;
      pend_bsel_nx_s = pend_bsel_r;
      pend_mode_nx_s = pend_mode_r;
      case (state_r)
         IDLE: begin
            if (mem_op_s && misalign_s) begin
               MisalignM  = 1'b1;
               valid_nx_s = 1'b1;
               word_nx_s  = 32'd0;
               bsel_nx_s  = lane_s;
               mode_nx_s  = NOREGWRITE;
            end else if (mem_op_s) begin
               StallM         = 1'b1;
               state_nx_s     = ACCESS;
               mem_req_nx_s   = 1'b1;
               mem_addr_nx_s  = AluOutM[ADDR_W-1:2];
               mem_we_nx_s    = we_align_s;
               mem_wd_nx_s    = wd_align_s;
               pend_load_nx_s = ~is_store_s;
               pend_bsel_nx_s = lane_s;
               pend_mode_nx_s = is_store_s ? NOREGWRITE : RegWriteM;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ACCESS: begin
            if (MemRdy) begin
               state_nx_s   = IDLE;
               mem_req_nx_s = 1'b0;
               valid_nx_s   = 1'b1;
               word_nx_s    = pend_load_r ? MemRD : 32'd0;
               bsel_nx_s    = pend_bsel_r;
               mode_nx_s    = pend_mode_r;
            end else begin
               StallM = 1'b1;
            end
         end
         default: begin
            state_nx_s   = IDLE;
            mem_req_nx_s = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset abandons any outstanding access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         MemReq      <= 1'b0;
         MemAddr     <= '0;
         MemWE       <= 4'b0000;
         MemWD       <= 32'd0;
         ValidW      <= 1'b0;
         WordW       <= 32'd0;
         ByteSelW    <= 2'b00;
         RegWriteW   <= NOREGWRITE;
         pend_load_r <= 1'b0;
         pend_bsel_r <= 2'b00;
         pend_mode_r <= NOREGWRITE;
      end else begin
         state_r     <= state_nx_s;
         MemReq      <= mem_req_nx_s;
         MemAddr     <= mem_addr_nx_s;
         MemWE       <= mem_we_nx_s;
         MemWD       <= mem_wd_nx_s;
         ValidW      <= valid_nx_s;
         WordW       <= word_nx_s;
         ByteSelW    <= bsel_nx_s;
         RegWriteW   <= mode_nx_s;
         pend_load_r <= pend_load_nx_s;
         pend_bsel_r <= pend_bsel_nx_s;
         pend_mode_r <= pend_mode_nx_s;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: the bench plays the data memory and keeps a
// scoreboard of expected retirements, compared whenever ValidW pulses.
module tb_mem_access_ctrl;

   localparam logic [2:0] NOREGWRITE = 3'd0;
   localparam logic [2:0] LB         = 3'd1;
   localparam logic [2:0] LH         = 3'd2;
   localparam logic [2:0] LW         = 3'd3;
   localparam logic [2:0] LBU        = 3'd4;
   localparam logic [2:0] LHU        = 3'd5;

   logic        clk, rst;
   logic        ReqValidM, MemReadM;
   logic [1:0]  StoreSizeM;
   logic [2:0]  RegWriteM;
   logic [31:0] AluOutM, StoreDataM;
   logic        StallM, MisalignM, MemReq;
   logic [29:0] MemAddr;
   logic [3:0]  MemWE;
   logic [31:0] MemWD;
   logic        MemRdy;
   logic [31:0] MemRD;
   logic        ValidW;
   logic [31:0] WordW;
   logic [1:0]  ByteSelW;
   logic [2:0]  RegWriteW;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  bsel;
      logic [2:0]  mode;
   } ret_t;

   ret_t sb[$];
   ret_t mon_e;
   ret_t last_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_ret = 0;
   int   n_push = 0;
   int   ret_mark;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .ReqValidM(ReqValidM), .MemReadM(MemReadM), .StoreSizeM(StoreSizeM),
      .RegWriteM(RegWriteM), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
      .StallM(StallM), .MisalignM(MisalignM),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD),
      .MemRdy(MemRdy), .MemRD(MemRD),
      .ValidW(ValidW), .WordW(WordW), .ByteSelW(ByteSelW), .RegWriteW(RegWriteW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Retirement monitor: every ValidW pulse pops one expected record.
   always @(negedge clk) begin
      if (!rst && ValidW) begin
         if (sb.size() == 0) begin
            check("unexpected_validw", 32'(ValidW), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("wordw", WordW, mon_e.word);
            check("byteselw", 32'(ByteSelW), 32'(mon_e.bsel));
            check("regwritew", 32'(RegWriteW), 32'(mon_e.mode));
            last_e = mon_e;
            n_ret++;
         end
      end
   end

   task automatic idle(input int n);
      ReqValidM = 1'b0;
      MemReadM  = 1'b0;
      StoreSizeM = 2'b00;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one op in M, act as a memory answering on the lat-th ACCESS cycle.
   task automatic run_op(input logic rd, input logic [1:0] ss, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] sd, input int lat,
                         input logic [31:0] rdata, input logic [3:0] exp_we,
                         input logic [31:0] exp_wd, input logic exp_mis);
      ret_t e;
      int   stalls;
      logic is_st;
      is_st  = (ss != 2'b00);
      e.word = (exp_mis || is_st) ? 32'd0 : rdata;
      e.bsel = addr[1:0];
      e.mode = (exp_mis || is_st) ? NOREGWRITE : mode;
      sb.push_back(e);
      n_push++;
      ReqValidM  = 1'b1;
      MemReadM   = rd;
      StoreSizeM = ss;
      RegWriteM  = mode;
      AluOutM    = addr;
      StoreDataM = sd;
      @(negedge clk);
      check("misalignm", 32'(MisalignM), 32'(exp_mis));
      check("stall_accept", 32'(StallM), 32'(!exp_mis));
      check("memreq_idle", 32'(MemReq), 32'd0);
      @(posedge clk);
      #1;
      if (exp_mis) begin
         check("memreq_misalign", 32'(MemReq), 32'd0);
         ReqValidM = 1'b0;
      end else begin
         check("memreq_issue", 32'(MemReq), 32'd1);
         check("memaddr", {2'b00, MemAddr}, {2'b00, addr[31:2]});
         check("memwe", 32'(MemWE), 32'(exp_we));
         check("memwd", MemWD, exp_wd);
         stalls = 1;
         for (int n = 1; n <= lat; n++) begin
            MemRdy = (n == lat);
            MemRD  = (n == lat) ? rdata : 32'hBAD0BAD0;
            @(negedge clk);
            check("stall_access", 32'(StallM), 32'(n != lat));
            check("memreq_held", 32'(MemReq), 32'd1);
            if (StallM) stalls++;
            @(posedge clk);
            #1;
         end
         MemRdy    = 1'b0;
         MemRD     = 32'hBAD0BAD0;
         ReqValidM = 1'b0;
         check("stall_cycles", 32'(stalls), 32'(lat));
         check("memreq_drop", 32'(MemReq), 32'd0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      ReqValidM  = 1'b0;
      MemReadM   = 1'b0;
      StoreSizeM = 2'b00;
      RegWriteM  = NOREGWRITE;
      AluOutM    = 32'd0;
      StoreDataM = 32'd0;
      MemRdy     = 1'b0;
      MemRD      = 32'hBAD0BAD0;
      #12;
      check("rst_memreq", 32'(MemReq), 32'd0);
      check("rst_validw", 32'(ValidW), 32'd0);
      check("rst_regwritew", 32'(RegWriteW), 32'(NOREGWRITE));
      check("rst_memwe", 32'(MemWE), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LW 0x100, zero-wait
      run_op(1'b1, 2'b00, LW, 32'h100, 32'd0, 1, 32'hDEADBEEF, 4'b0000, 32'd0, 1'b0);
      // SB 0xA5 to 0x203, ready on the third access cycle
      run_op(1'b0, 2'b01, LB, 32'h203, 32'h000000A5, 3, 32'h11111111, 4'b1000, 32'hA5000000, 1'b0);
      // SH to 0x102
      run_op(1'b0, 2'b10, LB, 32'h102, 32'h1234BEEF, 2, 32'h22222222, 4'b1100, 32'hBEEF0000, 1'b0);
      // LHU at 0x102
      run_op(1'b1, 2'b00, LHU, 32'h102, 32'd0, 1, 32'hCAFEF00D, 4'b0000, 32'd0, 1'b0);
      idle(1);

      // Non-memory instructions: no stall, no retire, W outputs hold
      ReqValidM = 1'b1; MemReadM = 1'b0; StoreSizeM = 2'b00; RegWriteM = LW; AluOutM = 32'h101;
      @(negedge clk);
      check("nonmem_stall", 32'(StallM), 32'd0);
      check("nonmem_misalign", 32'(MisalignM), 32'd0);
      @(posedge clk); #1;
      ReqValidM = 1'b0; MemReadM = 1'b1;
      @(negedge clk);
      check("invalid_stall", 32'(StallM), 32'd0);
      check("hold_validw", 32'(ValidW), 32'd0);
      check("hold_wordw", WordW, 32'hCAFEF00D);
      check("hold_regwritew", 32'(RegWriteW), 32'(LHU));
      check("hold_byteselw", 32'(ByteSelW), 32'h2);
      idle(1);

      // Misaligned ops and an unaligned-but-legal byte store
      run_op(1'b1, 2'b00, LW, 32'h101, 32'd0, 1, 32'h0, 4'b0000, 32'd0, 1'b1);
      run_op(1'b0, 2'b10, LB, 32'h103, 32'h5555, 1, 32'h0, 4'b0000, 32'd0, 1'b1);
      run_op(1'b1, 2'b00, LH, 32'h105, 32'd0, 1, 32'h0, 4'b0000, 32'd0, 1'b1);
      run_op(1'b0, 2'b01, LB, 32'h7, 32'h0000003C, 1, 32'h33333333, 4'b1000, 32'h3C000000, 1'b0);
      // Store with MemReadM also set behaves as a store
      run_op(1'b1, 2'b11, LW, 32'h10, 32'h0BADF00D, 1, 32'h77777777, 4'b1111, 32'h0BADF00D, 1'b0);
      idle(2);

      // Back-to-back LB 0x3 then SW 0x8, zero-wait
      ret_mark = n_ret;
      run_op(1'b1, 2'b00, LB, 32'h3, 32'd0, 1, 32'h89ABCDEF, 4'b0000, 32'd0, 1'b0);
      run_op(1'b0, 2'b11, LB, 32'h8, 32'h11223344, 1, 32'h44444444, 4'b1111, 32'h11223344, 1'b0);
      idle(3);
      check("b2b_pulses", 32'(n_ret - ret_mark), 32'd2);

      // Put non-reset values into W, then reset in the middle of an access
      run_op(1'b1, 2'b00, LBU, 32'h1, 32'd0, 1, 32'h55AA55AA, 4'b0000, 32'd0, 1'b0);
      ReqValidM = 1'b1; MemReadM = 1'b1; StoreSizeM = 2'b00; RegWriteM = LW;
      AluOutM = 32'h200; StoreDataM = 32'hFFFFFFFF;
      @(posedge clk); #1;
      check("pre_rst_memreq", 32'(MemReq), 32'd1);
      #2;
      rst = 1'b1;
      ReqValidM = 1'b0;
      #1;
      check("rst_access_memreq", 32'(MemReq), 32'd0);
      check("rst_access_memaddr", {2'b00, MemAddr}, 32'd0);
      check("rst_access_memwd", MemWD, 32'd0);
      check("rst_access_wordw", WordW, 32'd0);
      check("rst_access_byteselw", 32'(ByteSelW), 32'd0);
      check("rst_access_regwritew", 32'(RegWriteW), 32'(NOREGWRITE));
      check("rst_access_stall", 32'(StallM), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      MemRdy = 1'b1; MemRD = 32'h12345678;
      @(negedge clk);
      check("late_rdy_stall", 32'(StallM), 32'd0);
      @(posedge clk); #1;
      MemRdy = 1'b0;
      @(negedge clk);
      check("late_rdy_validw", 32'(ValidW), 32'd0);
      check("late_rdy_memreq", 32'(MemReq), 32'd0);
      idle(2);

      check("sb_empty", 32'(sb.size()), 32'd0);
      check("retire_count", 32'(n_ret), 32'(n_push));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage load/store controller for the pipelined RV32 core. It sits between the EX/MEM segment register and the data memory, and feeds the MEM/WB boundary, i.e. the load-extension stage. It aligns store data and byte enables, and runs a request/ready handshake to a variable-latency data memory. While an access is outstanding it stalls the pipeline. It then registers the returned 32-bit word, byte-select bits and load mode for the write-back extension logic.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ReqValidM  in  1  EX/MEM holds a valid instruction this cycle.
- MemReadM  in  1  instruction is a load.
- StoreSizeM  in  2  00 none, 01 SB, 10 SH, 11 SW.
- RegWriteM  in  3  load mode (`LB`/`LH`/`LW`/`LBU`/`LHU` from Parameters.v), used when MemReadM=1.
- AluOutM  in  ADDR_W  byte address.
- StoreDataM  in  32  unaligned store data (value in low bits).
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- MisalignM  out  1  misaligned access detected (combinational).
- MemReq  out  1  memory request (registered).
- MemAddr  out  ADDR_W-2  word address (registered).
- MemWE  out  4  byte write enables, 0 for loads (registered).
- MemWD  out  32  lane-aligned write data (registered).
- MemRdy  in  1  memory completes the access this cycle.
- MemRD  in  32  read word, valid when MemRdy=1.
- ValidW  out  1  one-cycle pulse: a memory op retired into W.
- WordW  out  32  loaded word for the extension stage.
- ByteSelW  out  2  AluOutM[1:0] of the retired load.
- RegWriteW  out  3  load mode of the retired op; `NOREGWRITE` for stores and misaligned ops.

## Operation
- Memory op: ReqValidM & (MemReadM | StoreSizeM!=0). If both MemReadM and StoreSizeM!=0 are set, the op is a store and MemReadM is ignored.
- Misaligned: half (`LH`/`LHU`/SH) with addr[0]=1, or word (`LW`/SW) with addr[1:0]!=0. Byte ops are never misaligned. A misaligned op:
  - asserts MisalignM;
  - issues no MemReq and does not stall;
  - retires next edge with ValidW=1, RegWriteW=`NOREGWRITE`, WordW=0.
- Store alignment, with a=addr[1:0]:
  - MemWD = StoreDataM << 8a.
  - MemWE = 4'b0001<<a (SB), 4'b0011<<a (SH), 4'b1111 (SW).
- FSM states:
  - IDLE: on an aligned memory op, assert StallM. On the edge, latch MemAddr, MemWE (0 for loads), MemWD, mode and byte select, set MemReq=1, go to ACCESS.
  - ACCESS: MemReq held, all Mem* outputs stable. While MemRdy=0: StallM=1, stay. When MemRdy=1: StallM=0. On the edge, WordW<=MemRD (loads) or 0 (stores), ValidW<=1, MemReq<=0, go to IDLE.
- Non-memory instructions pass without stall. ValidW stays 0 and WordW, ByteSelW and RegWriteW hold their values.
- MemRdy while in IDLE is ignored.

## Timing
- Reset values: MemReq=0, MemAddr=0, MemWE=0, MemWD=0, ValidW=0, WordW=0, ByteSelW=0, RegWriteW=`NOREGWRITE`, state=IDLE.
- StallM and MisalignM are combinational from the M inputs and current state.
- Latency from op present in M to ValidW: 1+N cycles, where N≥1 is the number of ACCESS cycles including the MemRdy cycle. A zero-wait memory gives 2 cycles, with StallM high exactly 1 cycle.
- Back-to-back memory ops: after the completing edge the FSM is in IDLE, so the next op begins its accept cycle immediately. No idle gap is required.
- ValidW is high for exactly one cycle per retired op.
- rst mid-ACCESS: MemReq drops asynchronously and the outstanding access is abandoned. A late MemRdy after reset is ignored.

## Test plan
- LW at 0x100 with zero-wait memory returning 0xDEADBEEF: StallM=1 for 1 cycle, MemAddr=0x40, MemWE=0. Next cycle ValidW=1, WordW=0xDEADBEEF, ByteSelW=0, RegWriteW=`LW`.
- SB of 0x000000A5 to 0x203 with MemRdy delayed 3 cycles: MemWE=4'b1000, MemWD=0xA5000000. StallM high 3 cycles. Then ValidW=1 with RegWriteW=`NOREGWRITE`.
- SH to 0x102: MemWE=4'b1100, MemWD=StoreDataM<<16. LHU at 0x102: ByteSelW=2'b10, RegWriteW=`LHU`.
- LW at 0x101: MisalignM=1, StallM=0, MemReq stays 0. Next cycle ValidW=1, RegWriteW=`NOREGWRITE`.
- Back-to-back LB 0x3 then SW 0x8, zero-wait: the second MemReq rises the cycle after the first completes. Exactly two ValidW pulses.
- rst asserted while in ACCESS with MemRdy=0: MemReq=0 within the same cycle, all outputs at reset values. A MemRdy pulse after reset produces no ValidW.
